cpu_cycle_sequencer: RTL and testbench
======================================

// Module: cpu_cycle_sequencer
// PURPOSE
//  Top-level cycle sequencer for the multi-cycle MIPS core. Drives the one-hot
//  fetch/exec1/exec2 strobes consumed by the PC and datapath, and the Avalon-style
//  read/write requests to the memory bus. Stalls on waitrequest, stops on PC halt,
//  and keeps a retired-instruction counter plus sticky bus-fault flags.
// PARAMETERS
//  COUNT_WIDTH   32  width of retired-instruction counter (wraps modulo 2^COUNT_WIDTH)
//  WAIT_TIMEOUT  0   max consecutive waitrequest cycles per access; 0 = no timeout
// PORTS
//  clk           in   1   system clock, all state on posedge
//  reset         in   1   asynchronous, active-high reset
//  waitrequest   in   1   memory not ready; current access must be held
//  halt          in   1   from PC: next address is 0, stop after current instruction
//  two_cycle     in   1   decoded instruction needs EXEC2 (loads, mult/div writeback, link)
//  data_rd_req   in   1   datapath requests data read during EXEC1
//  data_wr_req   in   1   datapath requests data write during EXEC1
//  fetch         out  1   FETCH-state strobe (one-hot with exec1/exec2)
//  exec1         out  1   EXEC1-state strobe
//  exec2         out  1   EXEC2-state strobe
//  read          out  1   memory read request (instruction or data)
//  write         out  1   memory write request
//  active        out  1   high from first FETCH until HALTED
//  instr_count   out  COUNT_WIDTH  retired-instruction count
//  proto_error   out  1   sticky: data_rd_req and data_wr_req both high in EXEC1
//  bus_timeout   out  1   sticky: waitrequest exceeded WAIT_TIMEOUT
// BEHAVIOUR
//  States: IDLE, FETCH, EXEC1, EXEC2, HALTED. Outputs are decoded from state
//   registered on posedge clk; no combinational path from waitrequest to the strobes.
//  reset asserted (any time, incl. mid-access): state=IDLE immediately; all outputs
//   0; instr_count=0; proto_error=bus_timeout=0; wait counter=0.
//  IDLE: strobes/read/write 0, active 0. First posedge after reset low -> FETCH.
//  FETCH: fetch=1, read=1, active=1. waitrequest=1 -> stay (read held).
//   waitrequest=0 -> EXEC1.
//  EXEC1: exec1=1. Memory op = data_rd_req | data_wr_req.
//   - Both requests high: write=1, read=0, proto_error set (sticky).
//   - Single request: drive read or write accordingly.
//   - Memory op and waitrequest=1 -> stay. waitrequest is ignored with no memory op.
//   - Otherwise leave: two_cycle=1 -> EXEC2; else halt=1 -> HALTED; else -> FETCH.
//  EXEC2: exec2=1, read=write=0, always 1 cycle. halt=1 -> HALTED, else -> FETCH.
//  Retire: instr_count += 1 on the edge leaving the final exec state (EXEC1 with
//   two_cycle=0, or EXEC2), including the halting instruction. Wraps to 0.
//  halt is sampled only on retire edges; halt during FETCH or a stall has no effect.
//  HALTED: absorbing until reset; all strobes, read, write and active are 0;
//   instr_count and sticky flags are held.
//  Timeout (WAIT_TIMEOUT>0): wait counter counts consecutive stalled cycles in
//   FETCH or EXEC1-with-memory-op, and clears on any non-stalled cycle. On the
//   stalled cycle that would make the count exceed WAIT_TIMEOUT: set bus_timeout,
//   drop read/write, go to HALTED. The counter saturates and does not wrap.
//  Invariant: at most one of fetch/exec1/exec2 high; read and write never both high.
// TESTING
//  1 reset, release, waitrequest=0, two_cycle=0, halt=0 for 3 instrs -> fetch/exec1
//    alternate each cycle, read high in FETCH only, instr_count=3 after 6 cycles.
//  2 load: two_cycle=1, data_rd_req=1, waitrequest high 2 cycles in EXEC1 -> exec1
//    held 3 cycles with read=1, then one exec2 cycle, instr_count +1.
//  3 halt=1 at end of EXEC2 -> HALTED next cycle, active=0, instr_count includes it;
//    further clocks change nothing; reset restarts from IDLE with count 0.
//  4 data_rd_req=data_wr_req=1 in EXEC1 -> write=1, read=0, proto_error=1 and
//    still 1 after later clean instructions.
//  5 WAIT_TIMEOUT=4, waitrequest stuck high in FETCH -> read held 4 stalled cycles,
//    on the 5th bus_timeout=1, read=0, state HALTED.
//  6 reset pulse mid-EXEC1 stall -> all outputs 0 without a clock edge; FETCH resumes
//    one cycle after release.

Source files
------------

// File: rtl/cpu_cycle_sequencer.sv
// Cycle sequencer for the multi-cycle MIPS core: one-hot fetch/exec1/exec2 strobes,
// Avalon-style read/write requests, retired-instruction counter and sticky bus faults.
module cpu_cycle_sequencer #(
    parameter int unsigned COUNT_WIDTH  = 32,
    parameter int unsigned WAIT_TIMEOUT = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   waitrequest,
    input  logic                   halt,
    input  logic                   two_cycle,
    input  logic                   data_rd_req,
    input  logic                   data_wr_req,
    output logic                   fetch,
    output logic                   exec1,
    output logic                   exec2,
    output logic                   read,
    output logic                   write,
    output logic                   active,
    output logic [COUNT_WIDTH-1:0] instr_count,
    output logic                   proto_error,
    output logic                   bus_timeout
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StExec1,
        StExec2,
        StHalted
    } state_t;

    localparam logic [31:0] TimeoutLimit = 32'(WAIT_TIMEOUT);
    localparam logic [31:0] WaitMax      = '1;

    state_t                 state_q, state_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic [31:0]            wait_q, wait_d;
    logic                   proto_q, proto_d;
    logic                   timeout_q, timeout_d;

    logic mem_op;
    logic stalled;
    logic retire;

    assign mem_op = data_rd_req | data_wr_req;

    // State, counters and sticky flags; reset takes effect without a clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            count_q   <= '0;
            wait_q    <= '0;
            proto_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            wait_q    <= wait_d;
            proto_q   <= proto_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state, strobe and bus-request decode from the registered state.
    always_comb begin
        state_d   = state_q;
        proto_d   = proto_q;
        timeout_d = timeout_q;
        fetch     = 1'b0;
        exec1     = 1'b0;
        exec2     = 1'b0;
        read      = 1'b0;
        write     = 1'b0;
        active    = 1'b0;
        stalled   = 1'b0;
        retire    = 1'b0;

        unique case (state_q)
            StIdle: begin
                state_d = StFetch;
            end
            StFetch: begin
                fetch  = 1'b1;
                read   = 1'b1;
                active = 1'b1;
                if (waitrequest) begin
                    stalled = 1'b1;
                end else begin
                    state_d = StExec1;
                end
            end
            StExec1: begin
                exec1  = 1'b1;
                active = 1'b1;
                // Conflicting requests resolve to a write and are flagged.
                if (data_rd_req && data_wr_req) begin
                    write   = 1'b1;
                    proto_d = 1'b1;
                end else if (data_rd_req) begin
                    read = 1'b1;
                end else if (data_wr_req) begin
                    write = 1'b1;
                end
                if (mem_op && waitrequest) begin
                    stalled = 1'b1;
                end else if (two_cycle) begin
                    state_d = StExec2;
                end else begin
                    retire  = 1'b1;
                    state_d = halt ? StHalted : StFetch;
                end
            end
            StExec2: begin
                exec2   = 1'b1;
                active  = 1'b1;
                retire  = 1'b1;
                state_d = halt ? StHalted : StFetch;
            end
            StHalted: begin
                state_d = StHalted;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // A stall that would push the wait count past the limit aborts the core.
        if (stalled && (WAIT_TIMEOUT != 0) && (wait_q >= TimeoutLimit)) begin
            timeout_d = 1'b1;
            state_d   = StHalted;
        end
    end

    // Retired-instruction count, wrapping modulo 2^COUNT_WIDTH.
    always_comb begin
        count_d = count_q;
        if (retire) begin
            count_d = count_q + COUNT_WIDTH'(1);
        end
    end

    // Consecutive-stall counter; clears on any non-stalled cycle and saturates.
    always_comb begin
        wait_d = '0;
        if (stalled) begin
            wait_d = (wait_q == WaitMax) ? wait_q : wait_q + 32'd1;
        end
    end

    assign instr_count = count_q;
    assign proto_error = proto_q;
    assign bus_timeout = timeout_q;

    // Structural invariants on the decoded outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert ($onehot0({fetch, exec1, exec2}))
                else $error("strobes not one-hot");
            assert (!(read && write))
                else $error("read and write both asserted");
        end
    end

endmodule

// File: tb/tb_cpu_cycle_sequencer.sv
// Directed bench for cpu_cycle_sequencer: a vector table for the main flow plus
// hand-written sequences for timeout, stall-counter clearing and async reset.
module tb_cpu_cycle_sequencer;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic waitrequest = 1'b0;
    logic halt = 1'b0;
    logic two_cycle = 1'b0;
    logic data_rd_req = 1'b0;
    logic data_wr_req = 1'b0;

    logic        fetch_a, exec1_a, exec2_a, read_a, write_a, active_a, proto_a, tmo_a;
    logic [31:0] count_a;
    logic        fetch_b, exec1_b, exec2_b, read_b, write_b, active_b, proto_b, tmo_b;
    logic [1:0]  count_b;

    logic [7:0] out_a, out_b;
    assign out_a = {fetch_a, exec1_a, exec2_a, read_a, write_a, active_a, proto_a, tmo_a};
    assign out_b = {fetch_b, exec1_b, exec2_b, read_b, write_b, active_b, proto_b, tmo_b};

    always #5 clk = ~clk;

    cpu_cycle_sequencer #(.COUNT_WIDTH(32), .WAIT_TIMEOUT(4)) dut_a (
        .clk(clk), .reset(reset), .waitrequest(waitrequest), .halt(halt),
        .two_cycle(two_cycle), .data_rd_req(data_rd_req), .data_wr_req(data_wr_req),
        .fetch(fetch_a), .exec1(exec1_a), .exec2(exec2_a), .read(read_a), .write(write_a),
        .active(active_a), .instr_count(count_a), .proto_error(proto_a), .bus_timeout(tmo_a)
    );

    // Narrow counter and no timeout: checks wrap and the unlimited-wait case.
    cpu_cycle_sequencer #(.COUNT_WIDTH(2), .WAIT_TIMEOUT(0)) dut_b (
        .clk(clk), .reset(reset), .waitrequest(waitrequest), .halt(halt),
        .two_cycle(two_cycle), .data_rd_req(data_rd_req), .data_wr_req(data_wr_req),
        .fetch(fetch_b), .exec1(exec1_b), .exec2(exec2_b), .read(read_b), .write(write_b),
        .active(active_b), .instr_count(count_b), .proto_error(proto_b), .bus_timeout(tmo_b)
    );

    // Expected output bits: {fetch, exec1, exec2, read, write, active, proto_error, bus_timeout}
    localparam logic [7:0] OIdle = 8'h00;
    localparam logic [7:0] OFet  = 8'h94;
    localparam logic [7:0] OE1   = 8'h44;
    localparam logic [7:0] OE1Rd = 8'h54;
    localparam logic [7:0] OE1Wr = 8'h4C;
    localparam logic [7:0] OE2   = 8'h24;
    localparam logic [7:0] OPe   = 8'h02;
    localparam logic [7:0] OTmo  = 8'h01;

    typedef struct {
        string       name;
        logic        rst, wr, hl, tc, dr, dw;
        logic [7:0]  out;
        logic [31:0] cnt;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_fail = 0;

    function automatic vec_t mk(input string name, input logic rst, input logic wr,
                                input logic hl, input logic tc, input logic dr, input logic dw,
                                input logic [7:0] out, input logic [31:0] cnt);
        vec_t v;
        v.name = name; v.rst = rst; v.wr = wr; v.hl = hl; v.tc = tc; v.dr = dr; v.dw = dw;
        v.out = out; v.cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_a(input string nm, input logic [7:0] o, input logic [31:0] c);
        chk({nm, " a.out"}, {24'd0, out_a}, {24'd0, o});
        chk({nm, " a.cnt"}, count_a, c);
    endtask

    task automatic cyc(input logic w, input logic h, input logic t, input logic r,
                       input logic q);
        @(negedge clk);
        waitrequest = w; halt = h; two_cycle = t; data_rd_req = r; data_wr_req = q;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        waitrequest = 1'b0; halt = 1'b0; two_cycle = 1'b0;
        data_rd_req = 1'b0; data_wr_req = 1'b0;
        #1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        //                  name          rst wr hl tc dr dw  out          cnt
        vecs.push_back(mk("reset",        1, 0, 0, 0, 0, 0, OIdle,         0));
        vecs.push_back(mk("idle",         0, 0, 0, 0, 0, 0, OIdle,         0));
        vecs.push_back(mk("i1 fetch",     0, 0, 0, 0, 0, 0, OFet,          0));
        vecs.push_back(mk("i1 exec1",     0, 0, 0, 0, 0, 0, OE1,           0));
        vecs.push_back(mk("i2 fetch",     0, 0, 0, 0, 0, 0, OFet,          1));
        vecs.push_back(mk("i2 exec1",     0, 0, 0, 0, 0, 0, OE1,           1));
        vecs.push_back(mk("i3 fetch",     0, 0, 0, 0, 0, 0, OFet,          2));
        vecs.push_back(mk("i3 exec1",     0, 0, 0, 0, 0, 0, OE1,           2));
        vecs.push_back(mk("ld fetch",     0, 0, 0, 0, 0, 0, OFet,          3));
        vecs.push_back(mk("ld stall1",    0, 1, 0, 1, 1, 0, OE1Rd,         3));
        vecs.push_back(mk("ld stall2",    0, 1, 0, 1, 1, 0, OE1Rd,         3));
        vecs.push_back(mk("ld exec1",     0, 0, 0, 1, 1, 0, OE1Rd,         3));
        vecs.push_back(mk("ld exec2",     0, 0, 0, 0, 0, 0, OE2,           3));
        vecs.push_back(mk("nomem fetch",  0, 0, 0, 0, 0, 0, OFet,          4));
        vecs.push_back(mk("nomem wr ign", 0, 1, 0, 0, 0, 0, OE1,           4));
        vecs.push_back(mk("pe fetch",     0, 0, 0, 0, 0, 0, OFet,          5));
        vecs.push_back(mk("pe both req",  0, 0, 0, 0, 1, 1, OE1Wr,         5));
        vecs.push_back(mk("pe sticky f",  0, 0, 0, 0, 0, 0, OFet | OPe,    6));
        vecs.push_back(mk("st exec1",     0, 0, 0, 0, 0, 1, OE1Wr | OPe,   6));
        vecs.push_back(mk("hl in stall",  0, 1, 1, 0, 0, 0, OFet | OPe,    7));
        vecs.push_back(mk("hl in fetch",  0, 0, 1, 0, 0, 0, OFet | OPe,    7));
        vecs.push_back(mk("hl exec1 tc",  0, 0, 1, 1, 0, 0, OE1 | OPe,     7));
        vecs.push_back(mk("hl exec2",     0, 0, 1, 0, 0, 0, OE2 | OPe,     7));
        vecs.push_back(mk("halted",       0, 0, 0, 0, 0, 0, OPe,           8));
        vecs.push_back(mk("halted hold",  0, 1, 1, 1, 1, 0, OPe,           8));
        vecs.push_back(mk("re-reset",     1, 0, 0, 0, 0, 0, OIdle,         0));
        vecs.push_back(mk("re-idle",      0, 0, 0, 0, 0, 0, OIdle,         0));
        vecs.push_back(mk("re fetch",     0, 0, 0, 0, 0, 0, OFet,          0));
        vecs.push_back(mk("hl exec1",     0, 0, 1, 0, 0, 0, OE1,           0));
        vecs.push_back(mk("halted e1",    0, 0, 0, 0, 0, 0, OIdle,         1));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            reset = vecs[i].rst; waitrequest = vecs[i].wr; halt = vecs[i].hl;
            two_cycle = vecs[i].tc; data_rd_req = vecs[i].dr; data_wr_req = vecs[i].dw;
            #1;
            chk_a(vecs[i].name, vecs[i].out, vecs[i].cnt);
            chk({vecs[i].name, " b.out"}, {24'd0, out_b}, {24'd0, vecs[i].out});
            chk({vecs[i].name, " b.cnt"}, {30'd0, count_b}, vecs[i].cnt & 32'd3);
        end

        // Timeout: stuck waitrequest in FETCH; dut_b has no limit and keeps waiting.
        do_reset();
        cyc(1, 0, 0, 0, 0);
        chk_a("to entry", OFet, 0);
        for (int i = 1; i <= 4; i++) begin
            cyc(1, 0, 0, 0, 0);
            chk_a($sformatf("to stall%0d", i), OFet, 0);
        end
        cyc(1, 0, 0, 0, 0);
        chk_a("to fired", OTmo, 0);
        chk("to b waiting", {24'd0, out_b}, {24'd0, OFet});
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0);
        chk_a("to halted hold", OTmo, 0);
        chk("to b still", {24'd0, out_b}, {24'd0, OFet});
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("to b exec1", {24'd0, out_b}, {24'd0, OE1});

        // Stall counter clears between accesses: 4 stalls in FETCH then 4 in EXEC1.
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk_a("clr fetch", OFet, 0);
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        chk_a("clr exec1", OE1Rd, 0);
        cyc(0, 0, 0, 0, 0);
        chk_a("clr retired", OFet, 1);

        // Asynchronous reset in the middle of an EXEC1 stall.
        do_reset();
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 1, 0);
        chk_a("ar stall", OE1Rd, 1);
        #2;
        reset = 1'b1;
        #1;
        chk_a("ar async", OIdle, 0);
        chk("ar b async", {24'd0, out_b}, {24'd0, OIdle});
        @(negedge clk);
        reset = 1'b0; waitrequest = 1'b0; data_rd_req = 1'b0;
        #1;
        chk_a("ar idle", OIdle, 0);
        cyc(0, 0, 0, 0, 0);
        chk_a("ar fetch", OFet, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
